// File: rtl/msg_reg.sv
// msg_reg: byte message buffer (circular FIFO) feeding a handshaked transmitter.
//   Parameter DEPTH          : buffer capacity in bytes (power of two, >= 2)
//   clk                      : clock, rising edge
//   nRst                     : asynchronous active-low reset
//   ready                    : receive strobe; its rising edge writes data
//   transmit_ready           : transmitter idle level (1 = can accept a byte)
//   data[7:0]                : received byte
//   blue                     : registered message-pending flag (buffer non-empty)
//   tx_ctrl                  : one-cycle transmit-start pulse
//   tx_byte[7:0]             : byte handed to the transmitter
//   Macro MSG_REG_OVERWRITE_EN: when defined, a write into a full buffer replaces
//   the oldest byte instead of being dropped.
module msg_reg #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic       ready,
    input  logic       transmit_ready,
    input  logic [7:0] data,
    output logic       blue,
    output logic       tx_ctrl,
    output logic [7:0] tx_byte
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);
    typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;
    state_t state_q, state_d;
    logic [7:0] mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0] count;
    logic ready_q, wr_ev, rd_ev, full, wr_acc, ovr;
    assign wr_ev = ready & ~ready_q;
    assign full = count == CNT_FULL;
    assign rd_ev = (state_q == IDLE) && transmit_ready && (count != '0);
    // a read on the same edge frees a slot, so a full buffer still accepts the write
    assign wr_acc = wr_ev && (!full || rd_ev);
`ifdef MSG_REG_OVERWRITE_EN
    assign ovr = wr_ev && full && !rd_ev;
`else
    assign ovr = 1'b0;
`endif
    assign tx_ctrl = state_q == SEND;
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = rd_ev ? SEND : IDLE;
            SEND:    state_d = WAIT;
            WAIT:    state_d = transmit_ready ? WAIT : IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            blue    <= 1'b0;
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            tx_byte <= 8'h00;
        end else begin
            state_q <= state_d;
            ready_q <= ready;
            blue    <= count != '0;
            if (wr_acc || ovr) wptr <= wptr + 1'b1;
            if (rd_ev || ovr) rptr <= rptr + 1'b1;
            if (rd_ev) tx_byte <= mem[rptr];
            count <= count + (AW + 1)'(wr_acc) - (AW + 1)'(rd_ev);
        end
    end
    // storage is not reset; pointers make stale contents unreachable
    always_ff @(posedge clk) begin
        if (wr_acc || ovr) mem[wptr] <= data;
    end
endmodule

// File: tb/tb_msg_reg.sv
// tb_msg_reg: directed vector table plus reset, full-buffer and same-cycle sequences for msg_reg.
module tb_msg_reg;
    localparam int DEPTH = 16;
`ifdef MSG_REG_OVERWRITE_EN
    localparam int OFS = 2;
`else
    localparam int OFS = 1;
`endif
    logic tb_clk, nRst, ready, transmit_ready, blue, tx_ctrl;
    logic [7:0] data, tx_byte;
    int checks = 0;
    int errors = 0;

    msg_reg #(.DEPTH(DEPTH)) dut (
        .clk(tb_clk), .nRst(nRst), .ready(ready), .transmit_ready(transmit_ready),
        .data(data), .blue(blue), .tx_ctrl(tx_ctrl), .tx_byte(tx_byte)
    );

    initial tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    typedef struct {
        logic       rdy;
        logic       trr;
        logic [7:0] d;
        logic       eb;
        logic       ec;
        logic [7:0] et;
    } vec_t;
    vec_t vecs [17];

    task automatic tick();
        @(posedge tb_clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic do_reset();
        nRst = 1'b0;
        ready = 1'b0;
        transmit_ready = 1'b0;
        tick();
        tick();
        nRst = 1'b1;
    endtask

    task automatic push(input logic [7:0] b);
        data = b;
        ready = 1'b1;
        tick();
        ready = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        nRst = 1'b0;
        ready = 1'b0;
        transmit_ready = 1'b0;
        data = 8'h00;
        //              rdy   trr   data   blue  ctrl  tx_byte
        vecs[0]  = '{1'b1, 1'b0, 8'h05, 1'b0, 1'b0, 8'h00};
        vecs[1]  = '{1'b1, 1'b0, 8'h05, 1'b1, 1'b0, 8'h00};
        vecs[2]  = '{1'b0, 1'b0, 8'h05, 1'b1, 1'b0, 8'h00};
        vecs[3]  = '{1'b0, 1'b1, 8'h05, 1'b1, 1'b1, 8'h05};
        vecs[4]  = '{1'b0, 1'b1, 8'h05, 1'b0, 1'b0, 8'h05};
        vecs[5]  = '{1'b0, 1'b1, 8'h05, 1'b0, 1'b0, 8'h05};
        vecs[6]  = '{1'b0, 1'b1, 8'h05, 1'b0, 1'b0, 8'h05};
        vecs[7]  = '{1'b0, 1'b0, 8'h05, 1'b0, 1'b0, 8'h05};
        vecs[8]  = '{1'b1, 1'b0, 8'hA1, 1'b0, 1'b0, 8'h05};
        vecs[9]  = '{1'b0, 1'b0, 8'hA1, 1'b1, 1'b0, 8'h05};
        vecs[10] = '{1'b1, 1'b1, 8'hB2, 1'b1, 1'b1, 8'hA1};
        vecs[11] = '{1'b0, 1'b1, 8'hB2, 1'b1, 1'b0, 8'hA1};
        vecs[12] = '{1'b0, 1'b0, 8'hB2, 1'b1, 1'b0, 8'hA1};
        vecs[13] = '{1'b0, 1'b1, 8'hB2, 1'b1, 1'b1, 8'hB2};
        vecs[14] = '{1'b0, 1'b0, 8'hB2, 1'b0, 1'b0, 8'hB2};
        vecs[15] = '{1'b0, 1'b0, 8'hB2, 1'b0, 1'b0, 8'hB2};
        vecs[16] = '{1'b0, 1'b0, 8'hB2, 1'b0, 1'b0, 8'hB2};

        do_reset();
        chk("reset_blue", {7'd0, blue}, 8'h00);
        chk("reset_tx_ctrl", {7'd0, tx_ctrl}, 8'h00);
        chk("reset_tx_byte", tx_byte, 8'h00);

        for (int i = 0; i < 17; i++) begin
            ready = vecs[i].rdy;
            transmit_ready = vecs[i].trr;
            data = vecs[i].d;
            tick();
            chk($sformatf("vec%0d_blue", i), {7'd0, blue}, {7'd0, vecs[i].eb});
            chk($sformatf("vec%0d_tx_ctrl", i), {7'd0, tx_ctrl}, {7'd0, vecs[i].ec});
            chk($sformatf("vec%0d_tx_byte", i), tx_byte, vecs[i].et);
        end

        // reset in WAIT with one byte still buffered
        do_reset();
        push(8'hC3);
        push(8'hD4);
        transmit_ready = 1'b1;
        tick();
        chk("midwait_send", {7'd0, tx_ctrl}, 8'h01);
        tick();
        chk("midwait_blue_before", {7'd0, blue}, 8'h01);
        #2;
        nRst = 1'b0;
        #1;
        chk("async_rst_blue", {7'd0, blue}, 8'h00);
        chk("async_rst_tx_ctrl", {7'd0, tx_ctrl}, 8'h00);
        chk("async_rst_tx_byte", tx_byte, 8'h00);
        tick();
        tick();
        nRst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("post_abort_tx_ctrl", {7'd0, tx_ctrl}, 8'h00);
            chk("post_abort_blue", {7'd0, blue}, 8'h00);
        end
        transmit_ready = 1'b0;

        // ready already high when reset releases counts as a write
        nRst = 1'b0;
        ready = 1'b1;
        data = 8'hE5;
        tick();
        tick();
        nRst = 1'b1;
        tick();
        tick();
        chk("held_ready_blue", {7'd0, blue}, 8'h01);
        ready = 1'b0;
        transmit_ready = 1'b1;
        tick();
        chk("held_ready_tx_ctrl", {7'd0, tx_ctrl}, 8'h01);
        chk("held_ready_tx_byte", tx_byte, 8'hE5);
        transmit_ready = 1'b0;
        tick();
        tick();

        // overfill by one, then drain
        do_reset();
        for (int i = 1; i <= DEPTH + 1; i++) push(8'(i));
        chk("full_blue", {7'd0, blue}, 8'h01);
        for (int i = 0; i < DEPTH; i++) begin
            bit seen;
            seen = 1'b0;
            transmit_ready = 1'b1;
            for (int w = 0; w < 5 && !seen; w++) begin
                tick();
                seen = tx_ctrl;
            end
            chk($sformatf("drain%0d_pulse", i), {7'd0, tx_ctrl}, 8'h01);
            chk($sformatf("drain%0d_byte", i), tx_byte, 8'(i + OFS));
            transmit_ready = 1'b0;
            tick();
            tick();
        end
        transmit_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("drained_tx_ctrl", {7'd0, tx_ctrl}, 8'h00);
        end
        chk("drained_blue", {7'd0, blue}, 8'h00);
        transmit_ready = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/msg_reg.md
MSG_REG -- requirements
Module: msg_reg

Interface
REQ-001 Parameter DEPTH, default 16, SHALL set the byte-buffer capacity; it is a power of two, at least 2.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 nRst  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 ready  input  1  SHALL be the receive-byte-valid strobe; data is captured on its rising edge.
REQ-005 transmit_ready  input  1  SHALL be the downstream transmitter-idle level (1 = can accept a byte).
REQ-006 data  input  8  SHALL be the received byte, valid while ready is high.
REQ-007 blue  output  1  SHALL be the message-pending indicator (1 = buffer non-empty).
REQ-008 tx_ctrl  output  1  SHALL be the transmit-start pulse to the transmitter.
REQ-009 tx_byte  output  8  SHALL be the byte handed to the transmitter.

Function
REQ-010 Buffer SHALL be a circular FIFO of DEPTH bytes, with write pointer, read pointer and a count of 0..DEPTH.
REQ-011 ready SHALL be registered each cycle; write event = ready high while the registered copy is low (rising edge); a held-high ready SHALL write exactly one byte.
REQ-012 On a write event with count < DEPTH, data SHALL be stored at the write pointer; pointer +1 modulo DEPTH; count +1.
REQ-013 A write event with count = DEPTH SHALL drop the byte; pointers and count unchanged (macro off).
REQ-014 Transmit FSM states: IDLE, SEND, WAIT.
REQ-015 IDLE -> SEND when transmit_ready = 1 and count > 0; otherwise stay in IDLE.
REQ-016 Entering SEND SHALL load tx_byte with the byte at the read pointer, advance the read pointer modulo DEPTH, and decrement count, all on that same clock edge.
REQ-017 tx_ctrl SHALL be 1 during exactly the one cycle spent in SEND, 0 in all other states.
REQ-018 SEND -> WAIT unconditionally after one cycle.
REQ-019 WAIT -> IDLE when transmit_ready = 0; while transmit_ready stays 1, stay in WAIT.
  - A continuously high transmit_ready therefore sends only one byte.
REQ-020 tx_byte SHALL hold its last value outside the SEND load.
REQ-021 Same-cycle write event and read (IDLE -> SEND) SHALL both take effect; count unchanged net.
REQ-022 With count = 1, a simultaneous write and read SHALL transmit the old byte and retain the new one.
REQ-023 Same-cycle write and read at count = DEPTH SHALL accept the write.
REQ-024 blue SHALL be registered, equal to (count != 0) as of the previous edge; it is 1 one cycle after a write into an empty buffer.

Reset
REQ-025 nRst low SHALL immediately clear the pointers, count, registered ready, blue (0), tx_ctrl (0) and tx_byte (8'h00), and force the FSM to IDLE.
REQ-026 Buffer contents need not be cleared; they are unreadable until rewritten.
REQ-027 Reset during SEND or WAIT SHALL abort the transfer; buffered bytes are lost.
REQ-028 Post-reset, a ready already high SHALL count as a rising edge on the first clock.

Configuration
REQ-029 With macro MSG_REG_OVERWRITE_EN defined, a write event with count = DEPTH SHALL overwrite the oldest byte: write pointer and read pointer both advance, count stays DEPTH.
REQ-030 Without MSG_REG_OVERWRITE_EN, REQ-013 (drop when full) SHALL apply.

Verification
REQ-031 Reset: nRst low 2 cycles with ready=0 -> blue=0, tx_ctrl=0, tx_byte=8'h00.
REQ-032 data=8'h05, ready held high, transmit_ready=0 -> one byte stored, blue=1 next cycle, tx_ctrl stays 0.
REQ-033 Then transmit_ready=1 held -> single tx_ctrl pulse, tx_byte=8'h05, blue=0 afterward, no further pulses.
REQ-034 Reset mid-WAIT with one byte buffered -> blue=0 and no tx_ctrl after release, even with transmit_ready=1.
REQ-035 DEPTH+1 ready pulses with bytes 1..DEPTH+1, then drain by toggling transmit_ready -> macro off: 1..DEPTH sent; macro on: 2..DEPTH+1 sent.
REQ-036 Count = 1, write event coinciding with IDLE -> SEND -> old byte sent, new byte retained, blue stays 1.
